// File: rtl/multdiv_sequencer.sv
// Sequencer for the shared multiply/divide unit in the execute stage.
// It latches the operands, issues one start pulse, and stalls the pipeline
// until the unit is ready or the watchdog expires. It then presents a
// one-cycle result, with an exception override, to the XM latch.
module multdiv_sequencer #(
    parameter int unsigned MAX_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [31:0] issue_A,
    input  logic [31:0] issue_B,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    input  logic        md_RDY,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    output logic [31:0] md_A,
    output logic [31:0] md_B,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [4:0]  result_rd
);

    localparam int unsigned CntW = $clog2(MAX_CYCLES) + 1;

    typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [31:0]       a_q, b_q, res_q;
    logic              is_div_q, exc_q;
    logic [4:0]        rd_q;
    logic [CntW-1:0]   cnt_q;

    logic accept;
    logic wait_live;
    logic timeout;

    assign accept    = (state_q == StIdle) && issue_valid && !flush;
    // A flush in WAIT wins over a ready or a timeout arriving in the same cycle.
    assign wait_live = (state_q == StWait) && !flush;
    assign timeout   = (cnt_q == CntW'(MAX_CYCLES - 1));

    assign md_A = a_q;
    assign md_B = b_q;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch, watchdog counter and result capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            rd_q     <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            exc_q    <= 1'b0;
        end else begin
            if (accept) begin
                a_q      <= issue_A;
                b_q      <= issue_B;
                is_div_q <= issue_is_div;
                rd_q     <= issue_rd;
            end
            if (state_q == StStart) begin
                cnt_q <= '0;
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q + CntW'(1);
            end
            if (wait_live) begin
                if (md_RDY) begin
                    res_q <= md_result;
                    exc_q <= md_exception;
                end else if (timeout) begin
                    res_q <= '0;
                    exc_q <= 1'b1;
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StStart;
            StStart: state_d = flush ? StIdle : StWait;
            StWait: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (md_RDY || timeout) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        ctrl_mult    = 1'b0;
        ctrl_div     = 1'b0;
        stall        = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        result       = '0;
        result_rd    = '0;
        case (state_q)
            // Gated by reset so a held issue_valid cannot stall during reset.
            StIdle:  stall = accept && reset;
            StStart: begin
                stall     = 1'b1;
                busy      = 1'b1;
                ctrl_mult = !is_div_q;
                ctrl_div  = is_div_q;
            end
            StWait: begin
                stall = 1'b1;
                busy  = 1'b1;
            end
            StDone: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                if (exc_q) begin
                    result_rd = 5'd30;
                    result    = is_div_q ? 32'd2 : 32'd1;
                end else begin
                    result_rd = rd_q;
                    result    = res_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer. The expected behaviour of each
// operation is predicted from a cycle timeline: issue at cycle 0, start
// pulse at 1, done at latency+2 or at MAXC+2 on timeout.
module tb_multdiv_sequencer;

    localparam int unsigned MAXC = 8;

    logic        clock;
    logic        reset;
    logic        issue_valid;
    logic        issue_is_div;
    logic [31:0] issue_A;
    logic [31:0] issue_B;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        md_RDY;
    logic [31:0] md_result;
    logic        md_exception;
    logic [31:0] md_A;
    logic [31:0] md_B;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  result_rd;

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    int op_id  = 0;

    multdiv_sequencer #(.MAX_CYCLES(MAXC)) dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_is_div (issue_is_div),
        .issue_A      (issue_A),
        .issue_B      (issue_B),
        .issue_rd     (issue_rd),
        .flush        (flush),
        .md_RDY       (md_RDY),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_A         (md_A),
        .md_B         (md_B),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .result_rd    (result_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s op%0d: observed %0h expected %0h", tag, op_id, obs, exp);
        end
    endtask

    task automatic check_quiet(input string where);
        check({where, ".stall"}, stall, 0);
        check({where, ".busy"}, busy, 0);
        check({where, ".ctrl_mult"}, ctrl_mult, 0);
        check({where, ".ctrl_div"}, ctrl_div, 0);
        check({where, ".result_valid"}, result_valid, 0);
    endtask

    // Cycles with no accepted instruction; optionally offer one with flush set.
    task automatic idle(input int n, input bit try_flush);
        for (int c = 0; c < n; c++) begin
            @(posedge clock);
            #1;
            issue_valid  = try_flush;
            flush        = try_flush;
            issue_is_div = 1'($urandom);
            issue_A      = $urandom;
            issue_B      = $urandom;
            issue_rd     = 5'($urandom);
            md_RDY       = 1'($urandom);
            md_result    = $urandom;
            md_exception = 1'($urandom);
            #1;
            check_quiet("idle");
        end
    endtask

    // One instruction. lat = WAIT cycles up to and including RDY (0 or >MAXC:
    // RDY never arrives). flush_at = cycle of a flush pulse, or -1.
    task automatic run_op(input bit div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input logic [31:0] mres,
                          input bit exc, input int flush_at);
        bit          rdy_ok;
        int          done_c;
        int          last;
        bit          exp_exc;
        logic [31:0] exp_res;
        logic [4:0]  exp_rd;
        op_id++;
        rdy_ok  = (lat >= 1) && (lat <= int'(MAXC));
        done_c  = rdy_ok ? lat + 2 : int'(MAXC) + 2;
        last    = (flush_at >= 1 && flush_at < done_c) ? flush_at : done_c;
        exp_exc = !rdy_ok || exc;
        exp_res = exp_exc ? (div ? 32'd2 : 32'd1) : mres;
        exp_rd  = exp_exc ? 5'd30 : rd;
        for (int c = 0; c <= last; c++) begin
            @(posedge clock);
            #1;
            issue_valid  = 1'b1;
            issue_is_div = div;
            issue_A      = (c == 0) ? a : $urandom;
            issue_B      = (c == 0) ? b : $urandom;
            issue_rd     = (c == 0) ? rd : 5'($urandom);
            flush        = (c == flush_at);
            if (rdy_ok && c == lat + 1) begin
                md_RDY       = 1'b1;
                md_result    = mres;
                md_exception = exc;
            end else begin
                // Ready outside WAIT must be ignored.
                md_RDY       = (c < 2 || c == done_c) ? 1'($urandom) : 1'b0;
                md_result    = $urandom;
                md_exception = 1'($urandom);
            end
            #1;
            check("stall", stall, c < done_c);
            check("busy", busy, c >= 1);
            check("ctrl_mult", ctrl_mult, c == 1 && !div);
            check("ctrl_div", ctrl_div, c == 1 && div);
            check("result_valid", result_valid, c == done_c);
            if (c >= 1) begin
                check("md_A", md_A, a);
                check("md_B", md_B, b);
            end
            if (c == done_c) begin
                check("result", result, exp_res);
                check("result_rd", result_rd, 32'(exp_rd));
            end
        end
    endtask

    initial begin
        reset        = 1'b0;
        issue_valid  = 1'b1;
        issue_is_div = 1'b0;
        issue_A      = 32'h5555_aaaa;
        issue_B      = 32'h1234_5678;
        issue_rd     = 5'd7;
        flush        = 1'b0;
        md_RDY       = 1'b1;
        md_result    = 32'hffff_ffff;
        md_exception = 1'b1;

        // Reset state, with issue_valid and md_RDY held high.
        repeat (2) @(posedge clock);
        #2;
        check_quiet("reset");
        check("reset.md_A", md_A, 0);
        check("reset.md_B", md_B, 0);
        check("reset.result", result, 0);
        check("reset.result_rd", result_rd, 0);
        @(negedge clock);
        issue_valid = 1'b0;
        md_RDY      = 1'b0;
        reset       = 1'b1;
        idle(2, 1'b0);

        // mult 7x6, RDY in the 4th WAIT cycle: done at cycle 6.
        run_op(1'b0, 32'd7, 32'd6, 5'd5, 4, 32'd42, 1'b0, -1);
        idle(1, 1'b0);
        // div 100/0 with exception: rd 30, result 2, single valid cycle.
        run_op(1'b1, 32'd100, 32'd0, 5'd9, 3, 32'hdead_beef, 1'b1, -1);
        idle(1, 1'b0);
        // Timeout: no RDY, done at cycle MAXC+2 with rd 30, result 1.
        run_op(1'b0, 32'd3, 32'd4, 5'd11, 0, 32'd0, 1'b0, -1);
        idle(1, 1'b0);
        // RDY on the very last watchdog cycle still delivers the real result.
        run_op(1'b1, 32'd50, 32'd5, 5'd12, int'(MAXC), 32'd10, 1'b0, -1);
        // Minimum latency, back-to-back into the next op.
        run_op(1'b0, 32'd2, 32'd3, 5'd13, 1, 32'd6, 1'b0, -1);
        // Back-to-back mult then div with issue_valid held high.
        run_op(1'b0, 32'd9, 32'd9, 5'd1, 2, 32'd81, 1'b0, -1);
        run_op(1'b1, 32'd81, 32'd9, 5'd2, 5, 32'd9, 1'b0, -1);
        // Flush at cycle 3 while RDY arrives in the same cycle.
        run_op(1'b0, 32'd8, 32'd8, 5'd3, 2, 32'd64, 1'b0, 3);
        idle(2, 1'b0);
        // Flush in START: the pulse still fires, no result follows.
        run_op(1'b1, 32'd8, 32'd2, 5'd4, 2, 32'd4, 1'b0, 1);
        idle(1, 1'b0);
        // Flush in DONE has no effect.
        run_op(1'b0, 32'd5, 32'd5, 5'd6, 2, 32'd25, 1'b0, 4);
        // issue_valid together with flush in IDLE is not accepted.
        idle(2, 1'b1);

        // Asynchronous reset between edges, mid-WAIT.
        op_id++;
        @(posedge clock);
        #1;
        issue_valid  = 1'b1;
        issue_is_div = 1'b0;
        issue_A      = 32'h1111_2222;
        issue_B      = 32'h3333_4444;
        issue_rd     = 5'd17;
        flush        = 1'b0;
        md_RDY       = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        check("midwait.busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check_quiet("midwait_reset");
        check("midwait_reset.md_A", md_A, 0);
        check("midwait_reset.md_B", md_B, 0);
        check("midwait_reset.result", result, 0);
        check("midwait_reset.result_rd", result_rd, 0);
        @(negedge clock);
        issue_valid = 1'b0;
        #2;
        reset = 1'b1;
        idle(4, 1'b0);

        // Randomized operations.
        for (int i = 0; i < 80; i++) begin
            bit div;
            bit exc;
            int lat;
            int done_c;
            int f;
            div    = 1'($urandom);
            exc    = ($urandom_range(3) == 0);
            lat    = int'($urandom_range(MAXC + 2));
            done_c = (lat >= 1 && lat <= int'(MAXC)) ? lat + 2 : int'(MAXC) + 2;
            f      = ($urandom_range(4) == 0) ? int'($urandom_range(done_c, 1)) : -1;
            run_op(div, $urandom, $urandom, 5'($urandom), lat, $urandom, exc, f);
            if ($urandom_range(1) == 1) begin
                idle(int'($urandom_range(2, 1)), 1'($urandom));
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
